// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers.
// Define UART_ARB_FIXED_PRIO_EN for strict lowest-index-wins priority instead of round-robin.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       arb_active,
    output logic                       timeout_err
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic               arb_active_q, arb_active_d;
    logic               timeout_err_q, timeout_err_d;
`ifndef UART_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
`endif

    logic [7:0]         req_bytes [NUM_REQ];
    logic               any_valid;
    logic [ID_W-1:0]    win_id;
    logic [7:0]         win_data;
    logic               timeout_hit;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign req_bytes[g] = req_data[8*g +: 8];
    end

    // Winner: first valid requester found searching upward from the start index, wrapping at NUM_REQ.
    always_comb begin
        int              base;
        int              idx;
        logic [ID_W-1:0] idx_w;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        any_valid = 1'b0;
        win_id    = '0;
        win_data  = '0;
        idx_w     = '0;
`ifdef UART_ARB_FIXED_PRIO_EN
        base = 0;
`else
        base = int'(rr_ptr_q);
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = base + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = ID_W'(idx);
            if (!any_valid && req_valid[idx_w]) begin
                any_valid = 1'b1;
                win_id    = idx_w;
                win_data  = req_bytes[idx_w];
            end
        end
    end

    assign timeout_hit = (cnt_q == CNT_W'(BUSY_TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!tx_busy && any_valid) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs; tx_data and grant_id only change on a grant.
    always_comb begin
        req_ready_d   = '0;
        tx_start_d    = 1'b0;
        timeout_err_d = 1'b0;
        tx_data_d     = tx_data_q;
        grant_id_d    = grant_id_q;
        cnt_d         = cnt_q;
        arb_active_d  = (state_d != IDLE);
`ifndef UART_ARB_FIXED_PRIO_EN
        rr_ptr_d      = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!tx_busy && any_valid) begin
                    req_ready_d[win_id] = 1'b1;
                    tx_data_d           = win_data;
                    grant_id_d          = win_id;
`ifndef UART_ARB_FIXED_PRIO_EN
                    if (win_id == ID_W'(NUM_REQ - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = win_id + ID_W'(1);
                    end
`endif
                end
            end
            GRANT: begin
                tx_start_d = 1'b1;
                cnt_d      = '0;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    cnt_d = '0;
                end else if (timeout_hit) begin
                    timeout_err_d = 1'b1;
                    cnt_d         = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                cnt_d = '0;
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            req_ready_q   <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            grant_id_q    <= '0;
            arb_active_q  <= 1'b0;
            timeout_err_q <= 1'b0;
`ifndef UART_ARB_FIXED_PRIO_EN
            rr_ptr_q      <= '0;
`endif
        end else begin
            cnt_q         <= cnt_d;
            req_ready_q   <= req_ready_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            grant_id_q    <= grant_id_d;
            arb_active_q  <= arb_active_d;
            timeout_err_q <= timeout_err_d;
`ifndef UART_ARB_FIXED_PRIO_EN
            rr_ptr_q      <= rr_ptr_d;
`endif
        end
    end

    assign req_ready   = req_ready_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_id_q;
    assign arb_active  = arb_active_q;
    assign timeout_err = timeout_err_q;

endmodule
